// File: rtl/mos_seq.sv
`default_nettype none
// ============================================================================
// Module   : mos_seq
// Purpose  : MOS on/off command FIFO and one-at-a-time req/ack sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module mos_seq #(
   parameter int DEPTH     = 4,
   parameter int REQ_HOLD  = 2,
   parameter int ACK_BLANK = 4,
   parameter int GAP_CYC   = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   input  logic                       cmd_val,
   output logic                       cmd_ready,
   input  logic                       flush,
   input  logic                       reg_seq_en,
   input  logic [15:0]                reg_timeout,
   input  logic                       err_clr,
   output logic                       mos_req,
   output logic                       mos_val,
   input  logic                       mos_ack,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout,
   output logic                       err_timeout,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [15:0]   C_HOLD_LAST = 16'(REQ_HOLD - 1);
   localparam logic [15:0]   C_BLANK     = 16'(ACK_BLANK);
   localparam logic [15:0]   C_GAP_LAST  = 16'(GAP_CYC - 1);
   localparam logic [LW-1:0] C_FULL_LVL  = LW'(DEPTH);

   logic [1:0]       state_q, state_d;
   logic [15:0]      timer_q, timer_d;
   logic             mos_req_q, mos_req_d;
   logic             mos_val_q, mos_val_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             err_q, err_d;
   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;

   logic        full, empty, push, pop;
   logic        in_txn, ack_ok, to_hit;
   logic [15:0] timer_inc;

   always_comb begin
      full      = (count_q == C_FULL_LVL);
      empty     = (count_q == '0);
      push      = cmd_valid && !full && !flush;
      pop       = (state_q == ST_IDLE) && reg_seq_en && !empty;
      in_txn    = (state_q == ST_REQ) || (state_q == ST_WAIT);
      // Blanking hides the downstream stage's stale ack level right after a rise
      ack_ok    = in_txn && mos_ack && (timer_q >= C_BLANK);
      to_hit    = in_txn && (reg_timeout != 16'd0) &&
                  (timer_q == reg_timeout - 16'd1) && !ack_ok;
      timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = cmd_val;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + LW'(push) - LW'(pop);
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      mos_req_d = mos_req_q;
      mos_val_d = mos_val_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      err_d     = err_clr ? 1'b0 : err_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               mos_val_d = mem_q[rd_ptr_q];
               mos_req_d = 1'b1;
               timer_d   = 16'd0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ, ST_WAIT: begin
            timer_d = timer_inc;
            if (ack_ok) begin
               done_d    = 1'b1;
               mos_req_d = 1'b0;
               timer_d   = 16'd0;
               state_d   = ST_GAP;
            end else if (to_hit) begin
               timeout_d = 1'b1;
               err_d     = 1'b1;
               mos_req_d = 1'b0;
               timer_d   = 16'd0;
               state_d   = ST_GAP;
            end else if ((state_q == ST_REQ) && (timer_q == C_HOLD_LAST)) begin
               mos_req_d = 1'b0;
               state_d   = ST_WAIT;
            end
         end
         ST_GAP: begin
            timer_d = timer_inc;
            if (timer_q == C_GAP_LAST) begin
               timer_d = 16'd0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         timer_q   <= 16'd0;
         mos_req_q <= 1'b0;
         mos_val_q <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         err_q     <= 1'b0;
         mem_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         mos_req_q <= mos_req_d;
         mos_val_q <= mos_val_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   assign cmd_ready   = !full;
   assign busy        = (state_q != ST_IDLE);
   assign fifo_level  = count_q;
   assign mos_req     = mos_req_q;
   assign mos_val     = mos_val_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign err_timeout = err_q;

endmodule
`default_nettype wire
